// File: rtl/index_table_builder.sv
`default_nettype none
// ============================================================================
// Module      : index_table_builder
// Description : Groups sparsity mask words, converts each group's non-zero
//               count into activation rows and writes an exclusive prefix sum
//               of rows into the index table, with a 3-cycle mask-control tap.
// Revision    : 1.0 - initial release
// ============================================================================
module index_table_builder #(
    parameter int MEM_BW           = 128,
    parameter int MASKS_PER_GROUP  = 2,
    parameter int ROW_ELEMS        = 16,
    parameter int ADDR_WIDTH_ACT   = 14,
    parameter int ADDR_WIDTH_MASKS = 11,
    parameter int ADDR_WIDTH_IDX   = 10
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        clear,
    input  logic [MEM_BW-1:0]           masks,
    input  logic                        mask_valid,
    input  logic                        mask_last,
    input  logic [ADDR_WIDTH_MASKS-1:0] mask_addr,
    output logic                        idx_we,
    output logic [ADDR_WIDTH_IDX-1:0]   idx_addr,
    output logic [ADDR_WIDTH_ACT-1:0]   idx_data,
    output logic [31:0]                 activation_rows_total,
    output logic                        delayed_valid,
    output logic [ADDR_WIDTH_MASKS-1:0] delayed_mask_addr,
    output logic                        done,
    output logic                        overflow
);

    localparam int c_acc_w  = $clog2(MEM_BW * MASKS_PER_GROUP) + 1;
    localparam int c_pc_w   = $clog2(MEM_BW) + 1;
    localparam int c_wig_w  = (MASKS_PER_GROUP > 1) ? $clog2(MASKS_PER_GROUP) : 1;
    localparam int c_row_sh = $clog2(ROW_ELEMS);
    localparam logic [c_wig_w-1:0] c_wig_last = c_wig_w'(MASKS_PER_GROUP - 1);
    localparam logic [32:0]        c_act_lim  = 33'(1) << ADDR_WIDTH_ACT;

    // Stage 1: input capture
    logic [MEM_BW-1:0]           r_s1_masks;
    logic                        r_s1_valid;
    logic                        r_s1_last;
    logic [ADDR_WIDTH_MASKS-1:0] r_s1_addr;

    // Stage 2: group accumulation
    logic [c_wig_w-1:0]          r_wig;
    logic [c_acc_w-1:0]          r_acc;
    logic                        r_s2_valid;
    logic                        r_s2_close;
    logic                        r_s2_last;
    logic [ADDR_WIDTH_MASKS-1:0] r_s2_addr;

    // Stage 3: row conversion and table write
    logic                        r_idx_we;
    logic [ADDR_WIDTH_IDX-1:0]   r_idx_addr;
    logic [ADDR_WIDTH_ACT-1:0]   r_idx_data;
    logic [31:0]                 r_total;
    logic [ADDR_WIDTH_IDX-1:0]   r_grp;
    logic                        r_done;
    logic                        r_overflow;
    logic                        r_dvalid;
    logic [ADDR_WIDTH_MASKS-1:0] r_daddr;

    logic [c_pc_w-1:0]           w_popcount;
    logic [c_acc_w-1:0]          w_acc_next;
    logic                        w_close;
    logic [31:0]                 w_rows;
    logic [32:0]                 w_sum;
    logic                        w_total_ovf;
    logic                        w_grp_wrap;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_s1_masks <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
        end else if (clear) begin
            r_s1_masks <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= mask_valid;
            r_s1_last  <= mask_last;
            r_s1_addr  <= mask_addr;
            if (mask_valid) begin
                r_s1_masks <= masks;
            end
        end
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < MEM_BW; i++) begin
            w_popcount = w_popcount + c_pc_w'(r_s1_masks[i]);
        end
    end

    assign w_acc_next = (r_wig == '0) ? c_acc_w'(w_popcount)
                                      : r_acc + c_acc_w'(w_popcount);
    assign w_close    = r_s1_last || (r_wig == c_wig_last);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_wig      <= '0;
            r_acc      <= '0;
            r_s2_valid <= 1'b0;
            r_s2_close <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_addr  <= '0;
        end else if (clear) begin
            r_wig      <= '0;
            r_acc      <= '0;
            r_s2_valid <= 1'b0;
            r_s2_close <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_addr  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_close <= r_s1_valid && w_close;
            r_s2_last  <= r_s1_valid && r_s1_last;
            // Gaps leave the word counter and accumulator untouched.
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                r_wig <= w_close ? '0 : r_wig + c_wig_w'(1);
            end
        end
    end

    // r_acc still holds the closed group's count while stage 3 consumes it.
    assign w_rows      = (32'(r_acc) + 32'(ROW_ELEMS - 1)) >> c_row_sh;
    assign w_sum       = {1'b0, r_total} + {1'b0, w_rows};
    assign w_total_ovf = (w_sum > c_act_lim);
    assign w_grp_wrap  = &r_grp;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_idx_we   <= 1'b0;
            r_idx_addr <= '0;
            r_idx_data <= '0;
            r_total    <= '0;
            r_grp      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_dvalid   <= 1'b0;
            r_daddr    <= '0;
        end else if (clear) begin
            r_idx_we   <= 1'b0;
            r_idx_addr <= '0;
            r_idx_data <= '0;
            r_total    <= '0;
            r_grp      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_dvalid   <= 1'b0;
            r_daddr    <= '0;
        end else begin
            r_idx_we <= r_s2_close;
            r_done   <= r_s2_close && r_s2_last;
            r_dvalid <= r_s2_valid;
            r_daddr  <= r_s2_addr;
            if (r_s2_close) begin
                r_idx_addr <= r_grp;
                r_idx_data <= r_total[ADDR_WIDTH_ACT-1:0];
                r_total    <= w_sum[31:0];
                r_grp      <= r_grp + ADDR_WIDTH_IDX'(1);
                if (w_total_ovf || w_grp_wrap) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign idx_we                = r_idx_we;
    assign idx_addr              = r_idx_addr;
    assign idx_data              = r_idx_data;
    assign activation_rows_total = r_total;
    assign delayed_valid         = r_dvalid;
    assign delayed_mask_addr     = r_daddr;
    assign done                  = r_done;
    assign overflow              = r_overflow;

endmodule
`default_nettype wire

// File: doc/index_table_builder.md
# index_table_builder

Parametrised index-table generator for the compressed-activation path. It consumes a stream of sparsity mask words and groups every `MASKS_PER_GROUP` consecutive words. For each group it counts the non-zero activations and converts the count into activation-memory rows of `ROW_ELEMS` elements, then writes the group's starting row into the index table, giving an exclusive prefix sum. It sits between the mask memory read port and the index-table SRAM, and forwards a delayed copy of the mask stream control for downstream address alignment.

## Interface
Parameters:
- `MEM_BW`, 128: mask word width in bits, i.e. elements per word.
- `MASKS_PER_GROUP`, 2: mask words per index-table entry; ≥1.
- `ROW_ELEMS`, 16: elements per activation-memory row; power of two.
- `ADDR_WIDTH_ACT`, 14: activation memory address width, also the `idx_data` width.
- `ADDR_WIDTH_MASKS`, 11: mask address width.
- `ADDR_WIDTH_IDX`, 10: index-table address width.

Ports:
- `clk` input 1: the single clock.
- `arst_n_in` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous start-of-layer clear.
- `masks` input MEM_BW: mask word.
- `mask_valid` input 1: `masks`, `mask_addr` and `mask_last` are valid this cycle.
- `mask_last` input 1: final word of the layer; only meaningful with `mask_valid`.
- `mask_addr` input ADDR_WIDTH_MASKS: mask address, passed through.
- `idx_we` output 1: index-table write strobe.
- `idx_addr` output ADDR_WIDTH_IDX: group index.
- `idx_data` output ADDR_WIDTH_ACT: starting row of the group.
- `activation_rows_total` output 32: running row total, including the group just written.
- `delayed_valid` output 1: `mask_valid` delayed 3 cycles.
- `delayed_mask_addr` output ADDR_WIDTH_MASKS: `mask_addr` delayed 3 cycles.
- `done` output 1: one-cycle pulse, coincident with the write of the final group.
- `overflow` output 1: sticky error flag.

## Operation
- Stage 1 registers the input word.
  - `masks` is captured only when `mask_valid` is high.
  - valid, last and addr are captured every cycle.
- Stage 2 computes the popcount of the registered word and updates the group accumulator.
  - Accumulator width is clog2(MEM_BW·MASKS_PER_GROUP)+1.
  - Word-in-group counter `wig` runs 0..MASKS_PER_GROUP-1.
  - When `wig==0`, the accumulator loads the popcount; otherwise it adds the popcount.
  - A group closes on `wig==MASKS_PER_GROUP-1` or on a last word. `wig` returns to 0 on close and otherwise increments.
  - Grouping depends only on the valid-word count, not on `mask_addr` parity.
- Stage 3 converts the closed group.
  - rows = (count + ROW_ELEMS-1) >> log2(ROW_ELEMS). A count of 0 gives 0 rows; no underflow is permitted.
  - Write: `idx_addr` = group counter, `idx_data` = total before the add, truncated to ADDR_WIDTH_ACT.
  - total += rows, and the group counter increments.
- Partial groups: a last word closes a partial group and it is written normally. `wig`, the group counter and the total are not reset by last; only `clear` or reset does that.
- `overflow` is set when either condition occurs, and is cleared only by `clear` or reset:
  - total after an add exceeds 2^ADDR_WIDTH_ACT;
  - the group counter wraps past 2^ADDR_WIDTH_IDX-1.
  - The write still occurs with wrapped address/data.
- `clear` has priority over everything in the same cycle:
  - zeroes `wig`, the group counter, the total, `overflow` and all stage valids;
  - discards in-flight words and any `mask_valid` word in the same cycle;
  - produces no `idx_we` from discarded words.
- Reset: every register and output is 0, including `idx_*`, the total, `done`, `overflow` and the delayed outputs.

## Timing
- `mask_valid` with a group-closing word in cycle N gives `idx_we`=1 in cycle N+3, with `idx_addr` and `idx_data` valid in the same cycle.
- `activation_rows_total` shows the updated total in cycle N+3 and holds it until the next write.
- `delayed_valid` and `delayed_mask_addr` in cycle N+3 equal the inputs of cycle N. They are unaffected by grouping and zeroed by `clear`.
- `done`=1 in N+3 for a last word in cycle N.
- Full throughput: one word per cycle, no back-pressure. Back-to-back groups of size 1 produce `idx_we` every cycle.
- Gaps (`mask_valid`=0) leave `wig` and the accumulators unchanged.

## Test plan
- Defaults; word popcounts 20, 13 → `idx_we` at N+3 with addr 0, data 0; total = 3 (33 elements → 3 rows).
- Next group of two all-zero words → addr 1, data 3, total stays 3 (zero-count group, no wrap); then two all-ones words → addr 2, data 3, total 19.
- MASKS_PER_GROUP=4 with words of popcount 16, 1, `mask_last` on the 2nd word → single write: addr 0, data 0, total 2; `done` pulse coincident with it.
- `clear` asserted one cycle after a group-closing word → no `idx_we`; total 0; next group written at addr 0, data 0.
- ADDR_WIDTH_ACT=4, all-ones groups (16 rows each) → second write: data 0 (wrapped), total 32, `overflow`=1 and held until `clear`.
- Assert `arst_n_in` low mid-stream → all outputs 0 immediately; after release, the first group is written at addr 0.
